// File: rtl/cs_resolve_pipe.sv
// cs_resolve_pipe
// Resolves a carry-save pair (in_a, in_b) into one binary sum, SEG_W bits per
// pipeline stage. This keeps any single carry chain to one segment.
// A tag travels with each pair.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_a, in_b, in_tag    carry-save pair and its sideband tag
//   out_valid/out_ready   output handshake
//   out_sum               in_a + in_b, SIZE_I+1 bits (top bit is the final carry)
//   out_tag               tag of the pair that produced out_sum
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The whole pipe moves together on adv = !out_valid | out_ready.
// in_ready is adv. It never looks at in_valid, and a held output freezes
// every stage.
module cs_resolve_pipe #(
  parameter int SIZE_I = 32,
  parameter int SEG_W  = 8,
  parameter int TAG_W  = 4,
  localparam int NUM_SEG = (SIZE_I + SEG_W - 1) / SEG_W,
  localparam int SIZE_O  = SIZE_I + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE_I-1:0] in_a,
  input  logic [SIZE_I-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE_O-1:0] out_sum,
  output logic [TAG_W-1:0]  out_tag
);

  // Top bit index (exclusive) resolved once stage s has run.
  function automatic int seg_hi(input int s);
    return ((s + 1) * SEG_W < SIZE_I) ? (s + 1) * SEG_W : SIZE_I;
  endfunction

  // Offset of stage s's resolved bits inside the flat r_q vector.
  function automatic int res_off(input int s);
    int o = 0;
    for (int k = 0; k < s; k++) o += seg_hi(k);
    return o;
  endfunction

  // Offset of stage s's still-unresolved a/b bits inside the flat up_*_q vectors.
  function automatic int up_off(input int s);
    int o = 0;
    for (int k = 0; k < s; k++) o += SIZE_I - seg_hi(k);
    return o;
  endfunction

  localparam int RES_TOT = res_off(NUM_SEG);
  localparam int UP_TOT  = up_off(NUM_SEG);
  localparam int UP_W    = (UP_TOT > 0) ? UP_TOT : 1;
  localparam int RL      = res_off(NUM_SEG - 1);

  // Per-stage registers, flattened so each stage can read its predecessor.
  logic [NUM_SEG-1:0]       v_q;
  logic [NUM_SEG-1:0]       c_q;
  logic [NUM_SEG*TAG_W-1:0] t_q;
  logic [RES_TOT-1:0]       r_q;
  logic [UP_W-1:0]          up_a_q;
  logic [UP_W-1:0]          up_b_q;

  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < NUM_SEG; s++) begin : g_stage
    localparam int LO  = (s == 0) ? 0 : seg_hi(s - 1);
    localparam int HI  = seg_hi(s);
    localparam int SW  = HI - LO;
    localparam int REM = SIZE_I - HI;
    localparam int RO  = res_off(s);

    // src_*: the unresolved bits entering this stage; the low SW bits are
    // this stage's segment, the rest pass through.
    logic [SIZE_I-LO-1:0] src_a;
    logic [SIZE_I-LO-1:0] src_b;
    logic                 cin;
    logic                 prev_v;
    logic [TAG_W-1:0]     prev_t;
    logic [HI-1:0]        r_next;
    logic [SW:0]          seg_sum;
    logic                 load;

    logic                 v;
    logic                 c;
    logic [TAG_W-1:0]     t;
    logic [HI-1:0]        r;

    assign seg_sum = {1'b0, src_a[SW-1:0]} + {1'b0, src_b[SW-1:0]} + {{SW{1'b0}}, cin};

    if (s == 0) begin : g_first
      assign src_a  = in_a;
      assign src_b  = in_b;
      assign cin    = 1'b0;
      assign prev_v = in_valid;
      assign prev_t = in_tag;
      assign r_next = seg_sum[SW-1:0];
    end else begin : g_next
      localparam int PU = up_off(s - 1);
      localparam int PR = res_off(s - 1);
      assign src_a  = up_a_q[PU +: SIZE_I-LO];
      assign src_b  = up_b_q[PU +: SIZE_I-LO];
      assign cin    = c_q[s-1];
      assign prev_v = v_q[s-1];
      assign prev_t = t_q[(s-1)*TAG_W +: TAG_W];
      assign r_next = {seg_sum[SW-1:0], r_q[PR +: LO]};
    end

    // Data only loads behind a valid slot, so bubbles leave the data
    // registers (and therefore out_sum) untouched.
    assign load = adv & prev_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        t <= '0;
        r <= '0;
      end else begin
        if (adv) v <= prev_v;
        if (load) begin
          c <= seg_sum[SW];
          t <= prev_t;
          r <= r_next;
        end
      end
    end

    assign v_q[s]                 = v;
    assign c_q[s]                 = c;
    assign t_q[s*TAG_W +: TAG_W]  = t;
    assign r_q[RO +: HI]          = r;

    if (REM > 0) begin : g_up
      localparam int UO = up_off(s);
      logic [REM-1:0] ua;
      logic [REM-1:0] ub;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ua <= '0;
          ub <= '0;
        end else if (load) begin
          ua <= src_a[SW +: REM];
          ub <= src_b[SW +: REM];
        end
      end

      assign up_a_q[UO +: REM] = ua;
      assign up_b_q[UO +: REM] = ub;
    end
  end

  // A single-stage pipe has no pass-through bits.
  if (UP_TOT == 0) begin : g_no_up
    assign up_a_q = '0;
    assign up_b_q = '0;
  end

  assign out_valid = v_q[NUM_SEG-1];
  assign out_tag   = t_q[(NUM_SEG-1)*TAG_W +: TAG_W];
  assign out_sum   = {c_q[NUM_SEG-1], r_q[RL +: SIZE_I]};

endmodule
